// File: rtl/bexkat_lsu.sv
// bexkat_lsu: single-outstanding load/store unit driving a Wishbone classic master with big-endian lanes.
// Define LSU_TIMEOUT_EN to add a bus-cycle watchdog that ends a stalled cycle after TIMEOUT clocks.
module bexkat_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);
  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);
  localparam int SW = LG + 2;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] w_n;
  logic [SW-1:0] w_sh, r_sh;
  logic [NB-1:0] w_bm, w_sel, r_sel;
  logic [DATA_W-1:0] w_dm, r_dm, w_dat, r_dat, w_raw, w_ld, r_rdata;
  logic [ADDR_W-1:0] r_adr;
  logic [1:0] r_err;
  logic r_we, r_signed, w_mis, w_acc, w_bus, w_fin, w_to, w_sbit;

  assign w_n = 4'd1 << req_size;
  assign w_mis = (|(req_addr[2:0] & (w_n[2:0] - 3'd1))) | (req_size > 2'(LG));
  // Lowest selected lane; the access fills lanes w_sh .. w_sh+n-1 with its MSB on the highest lane.
  assign w_sh = SW'(NB) - SW'(req_addr[LG-1:0]) - SW'(w_n);
  assign w_bm = ~({NB{1'b1}} << w_n);
  assign w_sel = w_bm << w_sh;
  assign w_dm = ~({DATA_W{1'b1}} << {w_n, 3'b000});
  assign w_dat = (req_wdata & w_dm) << {w_sh, 3'b000};
  assign w_raw = (wb_dat_i >> {r_sh, 3'b000}) & r_dm;
  assign w_sbit = |(w_raw & (r_dm ^ (r_dm >> 1)));
  assign w_ld = w_raw | ({DATA_W{r_signed & w_sbit}} & ~r_dm);
  assign w_acc = (r_state == IDLE) & req_valid;
  assign w_bus = r_state == BUS;
  assign w_fin = w_bus & (wb_err_i | wb_ack_i | w_to);

  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err = r_err;
  assign wb_cyc_o = w_bus;
  assign wb_stb_o = w_bus;
  assign wb_we_o = w_bus & r_we;
  assign wb_adr_o = w_bus ? r_adr : '0;
  assign wb_sel_o = w_bus ? r_sel : '0;
  assign wb_dat_o = w_bus ? r_dat : '0;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_cnt <= '0;
    else r_cnt <= w_bus ? r_cnt + 1'b1 : '0;
  assign w_to = w_bus & (r_cnt == CW'(TIMEOUT - 1));
`else
  // No watchdog: a legal (positive) limit can never fire, so BUS waits for ack or err.
  assign w_to = TIMEOUT < 0;
`endif

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_mis ? RESP : BUS;
    else if (w_fin) w_next = RESP;
    else if (rsp_valid && rsp_ready) w_next = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_we <= 1'b0;
      r_signed <= 1'b0;
      r_sh <= '0;
      r_sel <= '0;
      r_dm <= '0;
      r_dat <= '0;
      r_adr <= '0;
      r_rdata <= '0;
      r_err <= 2'b00;
    end else if (w_acc) begin
      r_we <= req_we;
      r_signed <= req_signed;
      r_sh <= w_sh;
      r_sel <= w_sel;
      r_dm <= w_dm;
      r_dat <= w_dat;
      r_adr <= {req_addr[ADDR_W-1:LG], {LG{1'b0}}};
      r_rdata <= '0;
      r_err <= w_mis ? 2'b01 : 2'b00;
    end else if (w_fin) begin
      r_rdata <= (wb_err_i | w_to | r_we) ? '0 : w_ld;
      r_err <= wb_err_i ? 2'b10 : wb_ack_i ? 2'b00 : 2'b11;
    end
endmodule

// File: tb/tb_bexkat_lsu.sv
// tb_bexkat_lsu: directed vector table plus hand sequences for stall, response hold and mid-cycle reset.
module tb_bexkat_lsu;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, wb_dat_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic req_ready, rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rsp_rdata, wb_adr_o, wb_dat_o;
  logic [1:0] rsp_err;
  logic [3:0] wb_sel_o;
  int checks = 0, errors = 0;

  bexkat_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic we; logic [1:0] size; logic sgn; logic [31:0] addr, wdata, bdat; logic berr;
    logic bus; logic [3:0] sel; logic [31:0] adr, dat, rdata; logic [1:0] err;
  } vec_t;
  vec_t tv[14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(logic we, logic [1:0] size, logic sgn, logic [31:0] addr, logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk_i);
    req_valid = 1'b0;
  endtask

  task automatic run(int id, vec_t v);
    string t = $sformatf("v%0d_", id);
    issue(v.we, v.size, v.sgn, v.addr, v.wdata);
    if (v.bus) begin
      chk({t, "cyc"}, 32'(wb_cyc_o), 32'd1);
      chk({t, "stb"}, 32'(wb_stb_o), 32'd1);
      chk({t, "we"}, 32'(wb_we_o), 32'(v.we));
      chk({t, "adr"}, wb_adr_o, v.adr);
      chk({t, "sel"}, 32'(wb_sel_o), 32'(v.sel));
      chk({t, "dat"}, wb_dat_o, v.dat);
      chk({t, "early_rsp"}, 32'(rsp_valid), 32'd0);
      wb_dat_i = v.bdat; wb_ack_i = 1'b1; wb_err_i = v.berr;
      @(negedge clk_i);
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
    end
    chk({t, "cyc_off"}, 32'(wb_cyc_o), 32'd0);
    chk({t, "rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({t, "rdata"}, rsp_rdata, v.rdata);
    chk({t, "err"}, 32'(rsp_err), 32'(v.err));
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk({t, "back_idle"}, 32'(req_ready), 32'd1);
    chk({t, "rsp_clr"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic hold_rsp(string t, logic [31:0] rdata, logic [1:0] err);
    for (int c = 0; c < 3; c++) begin
      chk({t, "hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({t, "hold_rdata"}, rsp_rdata, rdata);
      chk({t, "hold_err"}, 32'(rsp_err), 32'(err));
      chk({t, "hold_busy"}, 32'(req_ready), 32'd0);
      @(negedge clk_i);
    end
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk({t, "hold_done"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    //          we    sz    sgn   addr          wdata         bus data      berr  bus   sel      adr           dat           rdata         err
    tv[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1001, 32'h0,        32'h11A2_3344, 1'b0, 1'b1, 4'b0100, 32'h0000_1000, 32'h0,        32'hFFFF_FFA2, 2'b00};
    tv[1]  = '{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'b0011, 32'h0000_2000, 32'h0000_BEEF, 32'h0,        2'b00};
    tv[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2001, 32'h0,        32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        2'b01};
    tv[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b1, 4'b1111, 32'h0000_3000, 32'h0,        32'h0,        2'b10};
    tv[4]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1001, 32'h0,        32'h11A2_3344, 1'b0, 1'b1, 4'b0100, 32'h0000_1000, 32'h0,        32'h0000_00A2, 2'b00};
    tv[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1000, 32'h0,        32'h11A2_3344, 1'b0, 1'b1, 4'b1000, 32'h0000_1000, 32'h0,        32'h0000_0011, 2'b00};
    tv[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_F0FF, 1'b0, 1'b1, 4'b0011, 32'h0000_1000, 32'h0,        32'hFFFF_F0FF, 2'b00};
    tv[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0,        32'h8001_F0FF, 1'b0, 1'b1, 4'b1100, 32'h0000_1000, 32'h0,        32'hFFFF_8001, 2'b00};
    tv[8]  = '{1'b0, 2'd2, 1'b1, 32'h0000_4004, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b1, 4'b1111, 32'h0000_4004, 32'h0,        32'hCAFE_F00D, 2'b00};
    tv[9]  = '{1'b1, 2'd0, 1'b0, 32'h0000_5003, 32'h0000_00AB, 32'h0,        1'b0, 1'b1, 4'b0001, 32'h0000_5000, 32'h0000_00AB, 32'h0,        2'b00};
    tv[10] = '{1'b1, 2'd0, 1'b0, 32'h0000_5000, 32'hFFFF_FF5A, 32'h0,        1'b0, 1'b1, 4'b1000, 32'h0000_5000, 32'h5A00_0000, 32'h0,        2'b00};
    tv[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'h0123_4567, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0000_6000, 32'h0123_4567, 32'h0,        2'b00};
    tv[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_7000, 32'h0,        32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        2'b01};
    tv[13] = '{1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h0000_0077, 32'h0,        1'b1, 1'b1, 4'b0100, 32'h0000_5000, 32'h0077_0000, 32'h0,        2'b10};

    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);

    for (int i = 0; i < 14; i++) run(i, tv[i]);

    issue(1'b0, 2'd2, 1'b0, 32'h0000_9008, 32'h0);
    n = 0;
`ifdef LSU_TIMEOUT_EN
    while (wb_cyc_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("to_cycles", 32'(n), 32'd16);
    hold_rsp("to_", 32'h0, 2'b11);
`else
    repeat (20) begin
      n += int'(wb_cyc_o);
      @(negedge clk_i);
    end
    chk("stall_cycles", 32'(n), 32'd20);
    chk("stall_cyc", 32'(wb_cyc_o), 32'd1);
    chk("stall_adr", wb_adr_o, 32'h0000_9008);
    chk("stall_no_rsp", 32'(rsp_valid), 32'd0);
    wb_dat_i = 32'h1357_2468; wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    hold_rsp("stall_", 32'h1357_2468, 2'b00);
`endif

    issue(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
    chk("mid_cyc", 32'(wb_cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("post_rst_cyc", 32'(wb_cyc_o), 32'd0);
    run(100, tv[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bexkat_lsu.md
BEXKAT_LSU -- requirements
Module: bexkat_lsu

Interface
- REQ-001: DATA_W, 32, Wishbone data width in bits; legal values 32 or 64; NB = DATA_W/8.
- REQ-002: ADDR_W, 32, byte address width.
- REQ-003: TIMEOUT, 256, bus-cycle watchdog limit in clocks; used only when LSU_TIMEOUT_EN is defined.
- REQ-004: clk_i  in  1  clock; all state changes on the rising edge.
- REQ-005: rst_i  in  1  reset, asynchronous, active-high.
- REQ-006: req_valid  in  1  core request present.
- REQ-007: req_ready  out  1  LSU accepts a request this cycle.
- REQ-008: req_we  in  1  1 = store, 0 = load.
- REQ-009: req_size  in  2  access size in bytes = 1 << req_size (byte, half, word, dword).
- REQ-010: req_signed  in  1  sign-extend load data.
- REQ-011: req_addr  in  ADDR_W  byte address.
- REQ-012: req_wdata  in  DATA_W  store data, right-justified.
- REQ-013: rsp_valid  out  1  response present.
- REQ-014: rsp_ready  in  1  core consumes the response.
- REQ-015: rsp_rdata  out  DATA_W  load data, right-justified and extended.
- REQ-016: rsp_err  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout.
- REQ-017: wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
- REQ-018: wb_adr_o  out  ADDR_W  req_addr with low log2(NB) bits forced to 0.
- REQ-019: wb_sel_o  out  NB  byte-lane enables.
- REQ-020: wb_dat_o  out  DATA_W  lane-steered store data.
- REQ-021: wb_dat_i  in  DATA_W; wb_ack_i  in  1; wb_err_i  in  1.

Function
- REQ-022: The FSM SHALL have three states: IDLE, BUS and RESP.
- REQ-023: req_ready SHALL be 1 only in IDLE; acceptance is req_valid & req_ready.
- REQ-024: On acceptance, all request fields SHALL be registered and the FSM SHALL go to BUS, or go directly to RESP with rsp_err=01 and no bus cycle if addr mod size != 0 or size > NB.
- REQ-025: In BUS, wb_cyc_o and wb_stb_o SHALL both be 1, and wb_we_o, wb_adr_o, wb_sel_o and wb_dat_o SHALL be held stable.
- REQ-026: Lanes are big-endian: byte offset k within the bus word SHALL map to lane NB-1-k, i.e. bits [8(NB-k)-1 : 8(NB-k-1)].
- REQ-027: wb_sel_o SHALL set exactly 1<<req_size contiguous lanes, starting at lane NB-1-offset and extending toward lane 0.
- REQ-028: wb_dat_o SHALL place the low (1<<req_size) bytes of req_wdata on the selected lanes; unselected lanes SHALL be 0.
- REQ-029: On wb_ack_i in BUS, a load SHALL capture the selected lanes right-justified into rsp_rdata, sign-extended if req_signed and zero-extended otherwise; a store SHALL return rsp_rdata=0. rsp_err SHALL be 00 and the FSM SHALL go to RESP.
- REQ-030: On wb_err_i in BUS (priority over wb_ack_i), the FSM SHALL go to RESP with rsp_err=10 and rsp_rdata=0.
- REQ-031: wb_cyc_o and wb_stb_o SHALL drop in the cycle after ack, err or timeout.
- REQ-032: In RESP, rsp_valid SHALL be 1 with rsp_rdata and rsp_err stable until rsp_ready; then the FSM SHALL return to IDLE (one bubble; no back-to-back acceptance).
- REQ-033: Minimum latency is acceptance → 1 cycle BUS (if ack is immediate) → RESP, so rsp_valid is asserted 2 cycles after acceptance.

Reset
- REQ-034: rst_i SHALL force IDLE at any time, including mid-BUS, immediately dropping wb_cyc_o and wb_stb_o.
- REQ-035: Reset values SHALL be: req_ready=1 after the reset releases, rsp_valid=0, rsp_rdata=0, rsp_err=00, all wb_* outputs 0, watchdog counter 0.

Configuration
- REQ-036: With LSU_TIMEOUT_EN defined, a counter SHALL clear on entry to BUS and increment each BUS cycle; when it reaches TIMEOUT with no ack or err, the FSM SHALL go to RESP with rsp_err=11.
- REQ-037: Without LSU_TIMEOUT_EN, no counter SHALL exist, BUS SHALL wait indefinitely, and rsp_err=11 SHALL never occur.

Verification (DATA_W=32)
- REQ-038: Signed byte load at 0x1001, wb_dat_i=0x11A23344 with immediate ack → wb_sel_o=0100, rsp_rdata=0xFFFFFFA2, rsp_err=00.
- REQ-039: Half store at 0x2002, req_wdata=0x1234BEEF → wb_sel_o=0011, wb_dat_o=0x0000BEEF, wb_adr_o=0x2000, wb_we_o=1.
- REQ-040: Half load at 0x2001 → no wb_cyc_o, rsp_valid with rsp_err=01 the cycle after acceptance.
- REQ-041: Word load with wb_err_i and wb_ack_i asserted together → rsp_err=10, rsp_rdata=0.
- REQ-042: LSU_TIMEOUT_EN defined, TIMEOUT=16, never ack → wb_cyc_o high for 16 cycles, then rsp_err=11; rsp_ready held low 3 cycles → response held stable.
- REQ-043: rst_i pulsed during BUS → wb_cyc_o=0 asynchronously, no rsp_valid, and the next request completes normally.
